// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Purpose  : Execute-stage controller for an iterative DATA_W-bit divider.
//            Latches a DIV/DIVU/REM/REMU request and holds the divider start
//            handshake while the divide runs. Stalls the pipeline for the
//            duration, and aborts into a drain state on flush. Completes with
//            a one-cycle register write-back of the quotient or remainder.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req_i, op_i        - divide request and funct3 (op_i[2] = divide class)
//            dividend_i, divisor_i, reg_waddr_i - rs1, rs2, rd
//            flush_i            - cancels the in-flight instruction
//            div_start_o        - divider start, held while running
//            div_dividend_o, div_divisor_o, div_op_o, div_reg_waddr_o
//                               - latched operands presented to the divider
//            div_ready_i, div_result_i ({rem, quo}), div_busy_i - divider status
//            stall_o            - pipeline hold
//            wb_we_o, wb_waddr_o, wb_wdata_o - write-back port
// Options  : `define DIV_RESULT_CACHE_EN to keep the last completed result.
//            A request whose keys match that result exactly is answered
//            without starting the divider.
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    input  logic [ADDR_W-1:0]     reg_waddr_i,
    input  logic                  flush_i,
    output logic                  div_start_o,
    output logic [DATA_W-1:0]     div_dividend_o,
    output logic [DATA_W-1:0]     div_divisor_o,
    output logic [2:0]            div_op_o,
    output logic [ADDR_W-1:0]     div_reg_waddr_o,
    input  logic                  div_ready_i,
    input  logic [2*DATA_W-1:0]   div_result_i,
    input  logic                  div_busy_i,
    output logic                  stall_o,
    output logic                  wb_we_o,
    output logic [ADDR_W-1:0]     wb_waddr_o,
    output logic [DATA_W-1:0]     wb_wdata_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_req_ok;
    logic                w_hit;
    logic [DATA_W-1:0]   w_hit_data;
    logic                w_launch;
    logic                w_hit_wb;
    logic                w_done;
    logic [DATA_W-1:0]   w_res_sel;

    // op[1] distinguishes REM/REMU (upper half) from DIV/DIVU (lower half).
    assign w_req_ok  = req_i && op_i[2] && !flush_i;
    assign w_res_sel = div_op_o[1] ? div_result_i[2*DATA_W-1:DATA_W]
                                   : div_result_i[DATA_W-1:0];

`ifdef DIV_RESULT_CACHE_EN
    logic                r_c_valid;
    logic [DATA_W-1:0]   r_c_dividend;
    logic [DATA_W-1:0]   r_c_divisor;
    logic [2:0]          r_c_op;
    logic [2*DATA_W-1:0] r_c_result;

    assign w_hit = r_c_valid && (dividend_i == r_c_dividend)
                             && (divisor_i  == r_c_divisor)
                             && (op_i       == r_c_op);
    assign w_hit_data = op_i[1] ? r_c_result[2*DATA_W-1:DATA_W]
                                : r_c_result[DATA_W-1:0];

    // Only results that were actually written back are remembered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid    <= 1'b0;
            r_c_dividend <= '0;
            r_c_divisor  <= '0;
            r_c_op       <= '0;
            r_c_result   <= '0;
        end else if (w_done) begin
            r_c_valid    <= 1'b1;
            r_c_dividend <= div_dividend_o;
            r_c_divisor  <= div_divisor_o;
            r_c_op       <= div_op_o;
            r_c_result   <= div_result_i;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    assign w_launch = (r_state == S_IDLE) && w_req_ok && !w_hit;
    assign w_hit_wb = (r_state == S_IDLE) && w_req_ok &&  w_hit;
    // Flush beats a coincident ready: that result is dropped.
    assign w_done   = (r_state == S_RUN) && div_ready_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        div_start_o = 1'b0;
        stall_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_o = w_launch;
                if (w_launch) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Drop start in the ready cycle so the divider cannot retrigger.
                div_start_o = !div_ready_i;
                stall_o     = 1'b1;
                if (flush_i) begin
                    w_state_nxt = S_DRAIN;
                end else if (div_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                // An aborted divider still pulses ready (zero result); only
                // busy going low means it is safe to accept new work.
                stall_o = 1'b1;
                if (!div_busy_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_dividend_o  <= '0;
            div_divisor_o   <= '0;
            div_op_o        <= '0;
            div_reg_waddr_o <= '0;
            wb_we_o         <= 1'b0;
            wb_waddr_o      <= '0;
            wb_wdata_o      <= '0;
        end else begin
            if (w_launch) begin
                div_dividend_o  <= dividend_i;
                div_divisor_o   <= divisor_i;
                div_op_o        <= op_i;
                div_reg_waddr_o <= reg_waddr_i;
            end
            wb_we_o <= w_done || w_hit_wb;
            if (w_done) begin
                wb_waddr_o <= div_reg_waddr_o;
                wb_wdata_o <= w_res_sel;
            end else if (w_hit_wb) begin
                wb_waddr_o <= reg_waddr_i;
                wb_wdata_o <= w_hit_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Execute-side controller that sits directly upstream of the iterative 32-bit divider and consumes its result.
- Accepts a decoded DIV/DIVU/REM/REMU request from ex and latches the operands.
- Drives and holds the divider's start handshake, stalls the pipeline while the divide runs, aborts cleanly on flush, and issues a one-cycle register write-back selecting quotient or remainder.

Parameters:
- DATA_W, 32, operand/result width; the divider result bus is 2*DATA_W.
- ADDR_W, 5, register address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- req_i  input  1  ex presents a divide-class instruction this cycle
- op_i  input  3  funct3: DIV=3'b100, DIVU=3'b101, REM=3'b110, REMU=3'b111
- dividend_i  input  DATA_W  rs1 value
- divisor_i  input  DATA_W  rs2 value
- reg_waddr_i  input  ADDR_W  rd
- flush_i  input  1  jump/interrupt cancels the in-flight instruction
- div_start_o  output  1  start to divider; held for the whole operation
- div_dividend_o  output  DATA_W  latched dividend
- div_divisor_o  output  DATA_W  latched divisor
- div_op_o  output  3  latched op
- div_reg_waddr_o  output  ADDR_W  latched rd
- div_ready_i  input  1  divider result valid
- div_result_i  input  2*DATA_W  {remainder, quotient}
- div_busy_i  input  1  divider not idle
- stall_o  output  1  hold the pipeline
- wb_we_o  output  1  write-back enable, one-cycle pulse
- wb_waddr_o  output  ADDR_W  write-back rd
- wb_wdata_o  output  DATA_W  write-back data

Behaviour:
- Reset values: all outputs are 0 and the state is IDLE. The divider shares rst, so a mid-operation reset leaves both blocks idle with no write-back.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - If req_i && op_i[2] && !flush_i: latch op_i, dividend_i, divisor_i and reg_waddr_i into the div_*_o registers, then go to RUN.
  - Ignore req_i while flush_i is high.
- RUN:
  - div_start_o = (state==RUN) && !div_ready_i. This is combinational, so start drops in the same cycle ready is seen and the divider never retriggers.
  - Latched operands stay stable throughout RUN.
- RUN, on div_ready_i && !flush_i:
  - Next cycle: wb_we_o=1, wb_waddr_o=latched rd.
  - wb_wdata_o = div_result_i[63:32] for REM/REMU; div_result_i[31:0] for DIV/DIVU.
  - Go to IDLE.
- RUN, on flush_i, including the same cycle as div_ready_i: flush wins, the result is discarded, no write-back, go to DRAIN.
- DRAIN:
  - div_start_o=0; ignore div_ready_i, because the aborted divider emits ready with a zero result.
  - When div_busy_i==0, go to IDLE.
- Divide by zero: the divider answers one cycle after start; the write-back returns quotient 0xFFFFFFFF (DIV/DIVU) or the dividend (REM/REMU).
- stall_o = (IDLE && req_i && op_i[2] && !flush_i) || RUN || DRAIN. stall_o is low in the write-back cycle.
- wb_we_o is high for exactly one cycle per completed request; wb_waddr_o and wb_wdata_o are held until the next write-back.
- Verification checks: while div_ready_i is high in RUN, div_op_i and div_reg_waddr_i must equal the latched values.
- Latency, nonzero divisor: request accepted at cycle 0, start from cycle 1, write-back about 36 cycles after acceptance.

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- When defined:
  - Store {dividend, divisor, op, 64-bit result} of the last completed non-flushed operation, plus a valid bit cleared on reset.
  - In IDLE, a request matching all three keys exactly is a hit: no divider start, stall_o stays low, and the write-back is issued the next cycle from the cached half.
  - A flushed hit produces no write-back.
- When undefined: no cache storage; every request runs the divider.

Test Plan:
- DIVU 100/7, rd=5 -> div_start_o held until ready; wb_we_o one pulse, wb_waddr_o=5, wb_wdata_o=14; stall_o low in the wb cycle.
- REM 0xFFFFFFF9 (-7) / 2 -> wb_wdata_o=0xFFFFFFFF; REMU 0xFFFFFFF9 / 2 -> 0x00000001.
- DIV 123/0 -> ready one cycle after start, wb_wdata_o=0xFFFFFFFF; REMU 123/0 -> 123.
- DIVU 1000/10 with flush_i at RUN cycle 10 -> start drops, DRAIN until busy=0, no wb_we_o; then DIVU 9/3 -> wb_wdata_o=3.
- flush_i coincident with div_ready_i -> no write-back, next request runs normally; reset mid-RUN -> all outputs 0, state IDLE.
- With DIV_RESULT_CACHE_EN: DIV 50/5 twice -> the second issues no div_start_o and wb_wdata_o=10 the next cycle; DIV 50/6 then misses and runs the divider.
